// File: rtl/ccff_bitstream_loader.sv
// Word-to-serial loader for a tile configuration chain, with an optional
// recirculating parity readback that leaves the chain contents unchanged.
//
// state  | meaning
// IDLE   | waiting for start, chain untouched
// LOAD   | taking words and shifting their bits into the chain, LSB first
// VERIFY | tail looped back to head for CHAIN_LEN shifts while its parity is taken
// DONE   | load (and readback, if requested) finished; waiting for the next start
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN  = 10,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  verify_en,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  ccff_head,
    output logic                  chain_shift_en,
    input  logic                  ccff_tail,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_W-1:0]      bit_count
);
    localparam int HC_W = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] FULL   = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(CHAIN_LEN - 1);
    localparam logic [HC_W-1:0]  DW_CNT = HC_W'(DATA_WIDTH);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [HC_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]      bit_count_q, bit_count_d;
    logic                  parity_q, parity_d;
    logic                  tparity_q, tparity_d;
    logic                  verify_q, verify_d;
    logic                  error_q, error_d;
    logic [31:0]           remaining;

    assign cfg_ready      = (state_q == S_LOAD) && (hold_cnt_q == '0) && (bit_count_q < FULL);
    assign chain_shift_en = ((state_q == S_LOAD) && (hold_cnt_q != '0)) || (state_q == S_VERIFY);
    assign ccff_head      = (state_q == S_LOAD)   ? hold_q[0] :
                            (state_q == S_VERIFY) ? ccff_tail : 1'b0;
    assign busy           = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign done           = (state_q == S_DONE);
    assign error          = error_q;
    assign bit_count      = bit_count_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_cnt_d  = hold_cnt_q;
        bit_count_d = bit_count_q;
        parity_d    = parity_q;
        tparity_d   = tparity_q;
        verify_d    = verify_q;
        error_d     = error_q;
        remaining   = 32'(FULL - bit_count_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    bit_count_d = '0;
                    parity_d    = 1'b0;
                    tparity_d   = 1'b0;
                    error_d     = 1'b0;
                    verify_d    = verify_en;
                end
            end
            S_LOAD: begin
                if (hold_cnt_q != '0) begin
                    hold_d      = hold_q >> 1;
                    hold_cnt_d  = hold_cnt_q - HC_W'(1);
                    bit_count_d = bit_count_q + CNT_W'(1);
                    parity_d    = parity_q ^ hold_q[0];
                    if (bit_count_q == LAST) begin
                        if (verify_q) begin
                            state_d     = S_VERIFY;
                            bit_count_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end else if (cfg_valid && cfg_ready) begin
                    // the last word may only be partly used; its upper bits never shift out
                    hold_d     = cfg_data;
                    hold_cnt_d = (remaining < 32'(DATA_WIDTH)) ? HC_W'(remaining) : DW_CNT;
                end
            end
            S_VERIFY: begin
                tparity_d   = tparity_q ^ ccff_tail;
                bit_count_d = bit_count_q + CNT_W'(1);
                if (bit_count_q == LAST) begin
                    state_d = S_DONE;
                    error_d = (tparity_q ^ ccff_tail) != parity_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_cnt_q  <= '0;
            bit_count_q <= '0;
            parity_q    <= 1'b0;
            tparity_q   <= 1'b0;
            verify_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_cnt_q  <= hold_cnt_d;
            bit_count_q <= bit_count_d;
            parity_q    <= parity_d;
            tparity_q   <= tparity_d;
            verify_q    <= verify_d;
            error_q     <= error_d;
        end
    end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a behavioural chain model on the serial
// port and a bit-list reference model for what should reach the chain.
module tb_ccff_bitstream_loader;
    localparam int CL = 10;
    localparam int DW = 8;

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b0;
    logic          start    = 1'b0;
    logic          verify_en = 1'b0;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready, ccff_head, chain_shift_en, ccff_tail;
    logic          busy, done, error;
    logic [3:0]    bit_count;

    logic          start8 = 1'b0;
    logic [7:0]    data8  = '0;
    logic          valid8 = 1'b0;
    logic          ready8, head8, shift8_en, busy8, done8, error8;
    logic [3:0]    bit_count8;

    logic [CL-1:0] chain_q = '0;
    logic          fault_now = 1'b0;
    bit            head_log [4096];
    int            shift_total = 0;
    bit            head8_log [64];
    int            shift8_total = 0;

    int errors = 0;
    int checks = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .DATA_WIDTH(DW)) u_dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .verify_en(verify_en),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .chain_shift_en(chain_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .error(error), .bit_count(bit_count)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(8), .DATA_WIDTH(8)) u_dut8 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start8), .verify_en(1'b0),
        .cfg_data(data8), .cfg_valid(valid8), .cfg_ready(ready8),
        .ccff_head(head8), .chain_shift_en(shift8_en), .ccff_tail(1'b0),
        .busy(busy8), .done(done8), .error(error8), .bit_count(bit_count8)
    );

    // Chain model: first bit shifted in ends up at index 0, which drives the tail.
    assign ccff_tail = chain_q[0] ^ fault_now;
    always @(posedge prog_clk) begin
        if (chain_shift_en) chain_q <= {ccff_head, chain_q[CL-1:1]};
    end

    always @(posedge prog_clk) begin
        if (chain_shift_en) begin
            head_log[shift_total % 4096] = ccff_head;
            shift_total = shift_total + 1;
        end
        if (shift8_en) begin
            head8_log[shift8_total % 64] = head8;
            shift8_total = shift8_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input bit ver,
                           input int fault_k, input int stall_n, input int gap_pct,
                           input bit glitch);
        logic [7:0]    words [2];
        bit            exp_bits [$];
        logic [CL-1:0] exp_vec, got_vec;
        int            base, idx, hs, late_ready, stall_left, prev_cnt, cyc;
        bit            glitched, exp_done_next, finished;

        words[0] = w0;
        words[1] = w1;
        exp_bits = {};
        for (int w = 0; w < 2; w++)
            for (int b = 0; b < DW; b++)
                if (exp_bits.size() < CL) exp_bits.push_back(words[w][b]);
        for (int i = 0; i < CL; i++) exp_vec[i] = exp_bits[i];

        @(negedge prog_clk);
        base = shift_total;
        start = 1'b1;
        verify_en = ver;
        cfg_valid = 1'b1;
        cfg_data = w0;
        chk("ready_low_at_start", cfg_ready, 0);
        @(negedge prog_clk);
        start = 1'b0;
        verify_en = $urandom_range(1);
        chk("load_entry_busy", busy, 1);
        chk("load_entry_cnt", bit_count, 0);
        chk("load_entry_flags", {done, error}, 0);

        idx = 0; hs = 0; late_ready = 0; stall_left = stall_n;
        glitched = 0; exp_done_next = 0; prev_cnt = 0; finished = 0;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (start) begin
                start = 1'b0;
                chk("start_ignored_busy", busy, 1);
                chk("start_ignored_cnt", bit_count, prev_cnt);
            end
            if (exp_done_next) begin
                chk("done_after_last_shift", done, 1);
                exp_done_next = 0;
            end
            if (done) begin
                finished = 1;
                break;
            end
            if (idx == 2 && cfg_ready) late_ready++;
            fault_now = (fault_k > 0) && ((shift_total - base) == CL + fault_k - 1);
            if (stall_left > 0 && idx == 1 && cfg_ready && bit_count == 8) begin
                cfg_valid = 1'b0;
                cfg_data = $urandom;
                chk("stall_no_shift", chain_shift_en, 0);
                chk("stall_cnt_frozen", bit_count, 8);
                stall_left--;
            end else begin
                cfg_valid = (idx < 2) && ($urandom_range(99) >= gap_pct);
                cfg_data = cfg_valid ? words[idx] : DW'($urandom);
            end
            if (cfg_valid && cfg_ready) begin
                idx++;
                hs++;
            end
            if (glitch && !glitched && busy && bit_count == 3) begin
                start = 1'b1;
                glitched = 1;
                prev_cnt = int'(bit_count) + int'(chain_shift_en);
            end
            if (!ver && chain_shift_en && bit_count == CL - 1) exp_done_next = 1;
            @(negedge prog_clk);
        end
        fault_now = 1'b0;
        cfg_valid = 1'b0;

        chk("finished_in_budget", finished, 1);
        chk("shift_pulses", shift_total - base, ver ? 2 * CL : CL);
        chk("handshakes", hs, 2);
        chk("ready_after_last_word", late_ready, 0);
        for (int i = 0; i < CL; i++) got_vec[i] = head_log[(base + i) % 4096];
        chk("head_sequence", got_vec, exp_vec);
        chk("final_bit_count", bit_count, CL);
        chk("error_flag", error, ver && fault_k > 0);
        chk("done_idle_outputs", {busy, chain_shift_en, ccff_head, cfg_ready}, 0);
        if (fault_k == 0) begin
            chk("chain_contents", chain_q, exp_vec);
            chk("tail_first_bit", ccff_tail, exp_vec[0]);
        end
        @(negedge prog_clk);
        chk("done_sticky", {done, error}, {1'b1, ver && fault_k > 0});
    endtask

    initial begin
        int cyc, base8, hs8, late8;
        logic [7:0] got8;

        #12;
        chk("rst_outputs", {busy, done, error, cfg_ready, chain_shift_en, ccff_head}, 0);
        chk("rst_bit_count", bit_count, 0);
        @(negedge prog_clk);
        pReset = 1'b1;
        @(negedge prog_clk);
        chk("idle_after_rst", {busy, done, cfg_ready, chain_shift_en}, 0);

        do_load(8'hA5, 8'h03, 0, 0, 0, 0, 0);
        do_load(8'hA5, 8'h03, 1, 0, 0, 0, 0);
        do_load(8'hA5, 8'h03, 1, 4, 0, 0, 0);
        do_load(8'hA5, 8'h03, 0, 0, 5, 0, 0);
        do_load(8'($urandom), 8'($urandom), 0, 0, 0, 0, 1);

        // reset in the middle of a load
        @(negedge prog_clk);
        start = 1'b1;
        verify_en = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = 8'($urandom);
        @(negedge prog_clk);
        start = 1'b0;
        for (cyc = 0; cyc < 50 && bit_count != 6; cyc++) @(negedge prog_clk);
        chk("reached_shift6", bit_count, 6);
        pReset = 1'b0;
        #1;
        chk("midrst_outputs", {busy, cfg_ready, chain_shift_en, done, error}, 0);
        chk("midrst_bit_count", bit_count, 0);
        cfg_valid = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b1;
        do_load(8'h5C, 8'h02, 1, 0, 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            bit ver;
            int fk;
            ver = 1'($urandom_range(1));
            fk = (ver && $urandom_range(2) == 0) ? $urandom_range(CL, 1) : 0;
            do_load(8'($urandom), 8'($urandom), ver, fk, 0, 30, 0);
        end

        // single-word chain on the second instance
        @(negedge prog_clk);
        base8 = shift8_total;
        start8 = 1'b1;
        valid8 = 1'b1;
        data8 = 8'h81;
        @(negedge prog_clk);
        start8 = 1'b0;
        hs8 = 0;
        late8 = 0;
        for (cyc = 0; cyc < 50 && !done8; cyc++) begin
            if (hs8 == 1 && ready8) late8++;
            if (valid8 && ready8) hs8++;
            @(negedge prog_clk);
        end
        valid8 = 1'b0;
        for (int i = 0; i < 8; i++) got8[i] = head8_log[(base8 + i) % 64];
        chk("w8_done", done8, 1);
        chk("w8_handshakes", hs8, 1);
        chk("w8_no_reready", late8, 0);
        chk("w8_shifts", shift8_total - base8, 8);
        chk("w8_head_bits", got8, 8'h81);
        chk("w8_bit_count", bit_count8, 8);
        chk("w8_idle_outputs", {busy8, error8, ready8, shift8_en}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
